// File: rtl/race_pkg.sv
// Shared types and constants for the race renderer: FSM states, move encodings, colours.
package race_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAW_BG,
        S_DRAW_CAR,
        S_WAIT_MOVE,
        S_ERASE_CAR,
        S_UPDATE_POS,
        S_REDRAW_CAR
    } state_t;

    typedef enum logic [1:0] {
        MV_STRAIGHT,
        MV_LEFT,
        MV_RIGHT
    } mv_t;

    // move_dir per car is one-hot {right,left,straight}
    localparam logic [2:0] DIR_STRAIGHT = 3'b001;
    localparam logic [2:0] DIR_LEFT     = 3'b010;
    localparam logic [2:0] DIR_RIGHT    = 3'b100;

    localparam logic [2:0] COL_OFF     = 3'b000;
    localparam logic [2:0] COL_BG_DEF  = 3'b010;
    localparam logic [2:0] COL_CAR_DEF = 3'b100;

    localparam int XW = 8;
    localparam int YW = 7;

endpackage

// File: rtl/race_pixel_scan.sv
// Raster counter over a W x H window, x fastest; done marks the last pixel and the
// counter wraps to the origin on the following advance.
module race_pixel_scan
    import race_pkg::*;
#(
    parameter int W = 160,
    parameter int H = 120
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          en,
    output logic [XW-1:0] cx,
    output logic [YW-1:0] cy,
    output logic          done
);

    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (clear) begin
            cx_d = '0;
            cy_d = '0;
        end else if (en) begin
            if (cx_q == XW'(W - 1)) begin
                cx_d = '0;
                cy_d = (cy_q == YW'(H - 1)) ? '0 : cy_q + YW'(1);
            end else begin
                cx_d = cx_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    assign cx   = cx_q;
    assign cy   = cy_q;
    assign done = (cx_q == XW'(W - 1)) && (cy_q == YW'(H - 1));

endmodule

// File: rtl/race_render_ctrl.sv
// Race game render controller: background/sprite plotting and per-car move servicing.
// Optional RACE_COLLISION_EN rejects moves that would overlap another car.
module race_render_ctrl
    import race_pkg::*;
#(
    parameter int         SCREEN_W   = 160,
    parameter int         SCREEN_H   = 120,
    parameter int         CAR_W      = 4,
    parameter int         CAR_H      = 4,
    parameter int         NUM_CARS   = 2,
    parameter int         STEP       = 1,
    parameter logic [2:0] BG_COLOUR  = COL_BG_DEF,
    parameter logic [2:0] CAR_COLOUR = COL_CAR_DEF
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  oneframe,
    input  logic [3*NUM_CARS-1:0] move_dir,
`ifdef RACE_COLLISION_EN
    output logic                  collision,
`endif
    output logic [7:0]            x,
    output logic [6:0]            y,
    output logic [2:0]            colour,
    output logic                  plot,
    output logic                  busy
);

    localparam int IW = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;

    function automatic int init_x(int i);
        return (i + 1) * SCREEN_W / (NUM_CARS + 1) - CAR_W / 2;
    endfunction

    state_t                        state_q, state_d;
    logic [NUM_CARS-1:0][XW-1:0]   car_x_q, car_x_d;
    logic [NUM_CARS-1:0][YW-1:0]   car_y_q, car_y_d;
    logic [NUM_CARS-1:0]           pend_q, pend_d;
    logic [NUM_CARS-1:0][1:0]      mv_q, mv_d;
    logic [IW-1:0]                 sel_q, sel_d, idx_q, idx_d;

    logic [XW-1:0] bx, sx, nx;
    logic [YW-1:0] by, sy, ny;
    logic          bg_done, spr_done, spr_en, hit;
    logic [IW-1:0] cur;

    assign spr_en = (state_q == S_DRAW_CAR) || (state_q == S_ERASE_CAR) ||
                    (state_q == S_REDRAW_CAR);
    assign cur    = (state_q == S_DRAW_CAR) ? idx_q : sel_q;

    race_pixel_scan #(.W(SCREEN_W), .H(SCREEN_H)) u_bg_scan (
        .clk(clock), .rst_n(resetn), .clear(state_q == S_IDLE),
        .en(state_q == S_DRAW_BG), .cx(bx), .cy(by), .done(bg_done)
    );

    race_pixel_scan #(.W(CAR_W), .H(CAR_H)) u_spr_scan (
        .clk(clock), .rst_n(resetn), .clear(state_q == S_IDLE),
        .en(spr_en), .cx(sx), .cy(sy), .done(spr_done)
    );

    // Candidate position for the selected car, with edge clamp / vertical wrap
    always_comb begin
        nx  = car_x_q[sel_q];
        ny  = car_y_q[sel_q];
        hit = 1'b0;
        case (mv_t'(mv_q[sel_q]))
            MV_LEFT:  nx = (int'(car_x_q[sel_q]) < STEP) ? '0
                                                         : XW'(int'(car_x_q[sel_q]) - STEP);
            MV_RIGHT: nx = (int'(car_x_q[sel_q]) + STEP > SCREEN_W - CAR_W)
                           ? XW'(SCREEN_W - CAR_W) : XW'(int'(car_x_q[sel_q]) + STEP);
            default:  ny = (int'(car_y_q[sel_q]) < STEP) ? YW'(SCREEN_H - CAR_H)
                                                         : YW'(int'(car_y_q[sel_q]) - STEP);
        endcase
`ifdef RACE_COLLISION_EN
        for (int j = 0; j < NUM_CARS; j++) begin
            if (IW'(j) != sel_q &&
                int'(nx) < int'(car_x_q[j]) + CAR_W && int'(car_x_q[j]) < int'(nx) + CAR_W &&
                int'(ny) < int'(car_y_q[j]) + CAR_H && int'(car_y_q[j]) < int'(ny) + CAR_H)
                hit = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        car_x_d = car_x_q;
        car_y_d = car_y_q;
        pend_d  = pend_q;
        mv_d    = mv_q;
        sel_d   = sel_q;
        idx_d   = idx_q;

        // Requests are only sampled on the frame tick; a pending car keeps its first move
        if (state_q != S_IDLE && oneframe) begin
            for (int i = 0; i < NUM_CARS; i++) begin
                if (!pend_q[i] &&
                    (move_dir[3*i +: 3] & (DIR_STRAIGHT | DIR_LEFT | DIR_RIGHT)) != '0) begin
                    pend_d[i] = 1'b1;
                    if ((move_dir[3*i +: 3] & DIR_STRAIGHT) != '0)  mv_d[i] = MV_STRAIGHT;
                    else if ((move_dir[3*i +: 3] & DIR_LEFT) != '0) mv_d[i] = MV_LEFT;
                    else                                            mv_d[i] = MV_RIGHT;
                end
            end
        end

        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_DRAW_BG;
                pend_d  = '0;
                idx_d   = '0;
                for (int i = 0; i < NUM_CARS; i++) begin
                    car_x_d[i] = XW'(init_x(i));
                    car_y_d[i] = YW'(SCREEN_H - CAR_H);
                end
            end
            S_DRAW_BG: if (bg_done) state_d = S_DRAW_CAR;
            S_DRAW_CAR: if (spr_done) begin
                if (idx_q == IW'(NUM_CARS - 1)) begin
                    idx_d   = '0;
                    state_d = S_WAIT_MOVE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_WAIT_MOVE: if (pend_q != '0) begin
                for (int i = NUM_CARS - 1; i >= 0; i--)
                    if (pend_q[i]) sel_d = IW'(i);
                state_d = S_ERASE_CAR;
            end
            S_ERASE_CAR: if (spr_done) state_d = S_UPDATE_POS;
            S_UPDATE_POS: begin
                if (!hit) begin
                    car_x_d[sel_q] = nx;
                    car_y_d[sel_q] = ny;
                end
                state_d = S_REDRAW_CAR;
            end
            S_REDRAW_CAR: if (spr_done) begin
                pend_d[sel_q] = 1'b0;
                state_d       = S_WAIT_MOVE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            car_x_q <= '0;
            car_y_q <= '0;
            pend_q  <= '0;
            mv_q    <= '0;
            sel_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            car_x_q <= car_x_d;
            car_y_q <= car_y_d;
            pend_q  <= pend_d;
            mv_q    <= mv_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
        end
    end

    // Pixel outputs decode straight from state so reset blanks them without a clock
    always_comb begin
        plot   = 1'b0;
        x      = '0;
        y      = '0;
        colour = COL_OFF;
        case (state_q)
            S_DRAW_BG: begin
                plot = 1'b1; x = bx; y = by; colour = BG_COLOUR;
            end
            S_DRAW_CAR, S_REDRAW_CAR: begin
                plot = 1'b1; x = car_x_q[cur] + sx; y = car_y_q[cur] + sy; colour = CAR_COLOUR;
            end
            S_ERASE_CAR: begin
                plot = 1'b1; x = car_x_q[cur] + sx; y = car_y_q[cur] + sy; colour = BG_COLOUR;
            end
            default: ;
        endcase
    end

    assign busy = (state_q != S_IDLE) && (state_q != S_WAIT_MOVE);

`ifdef RACE_COLLISION_EN
    assign collision = (state_q == S_UPDATE_POS) && hit;
`endif

endmodule

// File: tb/tb_race_render_ctrl.sv
// Directed bench for race_render_ctrl: startup draw, move servicing, clamps, wrap and reset.
module tb_race_render_ctrl;

    logic       clock = 1'b0, resetn = 1'b0, start = 1'b0, oneframe = 1'b0;
    logic [5:0] move_dir = '0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy;
`ifdef RACE_COLLISION_EN
    logic       collision;
`endif
    int checks = 0, errors = 0, bad = 0;

    always #5 clock = ~clock;

    race_render_ctrl dut (
        .clock(clock), .resetn(resetn), .start(start), .oneframe(oneframe),
        .move_dir(move_dir),
`ifdef RACE_COLLISION_EN
        .collision(collision),
`endif
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic pix(input int ex, input int ey, input int ec, input int ep);
        if (plot !== 1'(ep)) bad++;
        else if (ep != 0 && (int'(x) !== ex || int'(y) !== ey || int'(colour) !== ec)) bad++;
    endtask

    task automatic sprite(input int ox, input int oy, input int col);
        for (int k = 0; k < 16; k++) begin
            pix(ox + k % 4, oy + k / 4, col, 1);
            tick();
        end
    endtask

    // Starts at the first erase pixel; ends on the WAIT_MOVE cycle after the redraw
    task automatic service(input int ox, input int oy, input int nx, input int ny,
                           input int ecol, input string tag);
        bad = 0;
        sprite(ox, oy, 2);
        pix(0, 0, 0, 0);
        if (busy !== 1'b1) bad++;
`ifdef RACE_COLLISION_EN
        if (collision !== 1'(ecol)) bad++;
`else
        if (ecol != 0) bad++;
`endif
        tick();
        sprite(nx, ny, 4);
        pix(0, 0, 0, 0);
        if (busy !== 1'b0) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic frame(input logic [5:0] d);
        move_dir = d; oneframe = 1'b1; tick();
        move_dir = '0; oneframe = 1'b0; tick();
    endtask

    task automatic move(input int c, input logic [2:0] d, input int ox, input int oy,
                        input int nx, input int ny, input int ecol, input string tag);
        frame((c == 0) ? {3'b000, d} : {d, 3'b000});
        service(ox, oy, nx, ny, ecol, tag);
    endtask

    task automatic reset_and_draw;
        resetn = 1'b0; start = 1'b0; tick(); tick();
        resetn = 1'b1; tick();
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_xyc", int'({x, y, colour}), 0);
        start = 1'b1; tick(); start = 1'b0;
        bad = 0;
        for (int i = 0; i < 19200; i++) begin
            pix(i % 160, i / 160, 2, 1);
            if (busy !== 1'b1) bad++;
            tick();
        end
        chk("bg_scan", bad, 0);
        bad = 0;
        sprite(51, 116, 4);
        sprite(104, 116, 4);
        chk("car_draw", bad, 0);
        chk("wait_plot", int'(plot), 0);
        chk("wait_busy", int'(busy), 0);
    endtask

    initial begin
        reset_and_draw();

        // Requests without a frame tick are dropped
        move_dir = 6'b001001; tick(); tick();
        move_dir = '0; tick(); tick();
        chk("no_tick_drop", int'({busy, plot}), 0);

        // Start outside IDLE must not restart the background
        start = 1'b1; tick(); start = 1'b0; tick();
        chk("start_ignored", int'({busy, plot}), 0);

        for (int i = 51; i > 0; i--) move(0, 3'b010, i, 116, i - 1, 116, 0, "left");
        move(0, 3'b010, 0, 116, 0, 116, 0, "left_clamp");

        // Same tick for both cars: car0 fully first, one idle cycle, then car1
        frame(6'b001001);
        service(0, 116, 0, 115, 0, "both_c0");
        tick();
        service(104, 116, 104, 115, 0, "both_c1");

        move(0, 3'b111, 0, 115, 0, 114, 0, "prio_straight");
        move(0, 3'b110, 0, 114, 0, 114, 0, "prio_left");

        for (int yy = 115; yy > 0; yy--) move(1, 3'b001, 104, yy, 104, yy - 1, 0, "straight");
        move(1, 3'b001, 104, 0, 104, 116, 0, "wrap");

`ifdef RACE_COLLISION_EN
        reset_and_draw();
        for (int i = 104; i > 100; i--) move(1, 3'b010, i, 116, i - 1, 116, 0, "c1_left");
        for (int i = 51; i < 96; i++) move(0, 3'b100, i, 116, i + 1, 116, 0, "c0_right");
        move(0, 3'b100, 96, 116, 96, 116, 1, "collide");
`endif

        // Reset landing in the middle of the background scan
        resetn = 1'b0; tick(); resetn = 1'b1; tick();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 5000; i++) tick();
        chk("pre_rst_x", int'(x), 40);
        chk("pre_rst_y", int'(y), 31);
        #1 resetn = 1'b0;
        #1;
        chk("mid_rst_plot", int'(plot), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_xyc", int'({x, y, colour}), 0);
        tick(); resetn = 1'b1; tick();
        start = 1'b1; tick(); start = 1'b0;
        bad = 0;
        for (int i = 0; i < 320; i++) begin
            pix(i % 160, i / 160, 2, 1);
            tick();
        end
        chk("redraw_origin", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/race_render_ctrl.md
RACE_RENDER_CTRL -- requirements
Module: race_render_ctrl

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, screen width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 120, screen height in pixels.
REQ-003 SHALL have parameter CAR_W, default 4, car sprite width.
REQ-004 SHALL have parameter CAR_H, default 4, car sprite height.
REQ-005 SHALL have parameter NUM_CARS, default 2, number of independently steered cars.
REQ-006 SHALL have parameter STEP, default 1, pixels moved per accepted move.
REQ-007 SHALL have parameters BG_COLOUR, default 3'b010, and CAR_COLOUR, default 3'b100, 3-bit pixel colours.
REQ-008 clock  input  1  single clock; all state updates on its rising edge.
REQ-009 resetn  input  1  asynchronous, active-low reset.
REQ-010 start  input  1  one-cycle pulse; starts a race from IDLE.
REQ-011 oneframe  input  1  one-cycle frame tick; move sampling strobe.
REQ-012 move_dir  input  3*NUM_CARS  per car one-hot {right,left,straight}.
REQ-013 x  output  8  pixel x; y  output  7  pixel y; colour  output  3  pixel colour.
REQ-014 plot  output  1  pixel write strobe, one pixel per cycle when high.
REQ-015 busy  output  1  high in every state except IDLE and WAIT_MOVE.

Function
REQ-016 States SHALL be IDLE, DRAW_BG, DRAW_CAR, WAIT_MOVE, ERASE_CAR, UPDATE_POS, REDRAW_CAR.
REQ-017 IDLE->DRAW_BG on start; DRAW_BG SHALL plot all SCREEN_W*SCREEN_H pixels in raster order (x fastest), BG_COLOUR, then go to DRAW_CAR.
REQ-018 DRAW_CAR SHALL plot CAR_W*CAR_H pixels for each car in index order 0..NUM_CARS-1, CAR_COLOUR, then go to WAIT_MOVE.
REQ-019 On oneframe, each car with any move_dir bit set SHALL latch a pending move (priority straight>left>right); already-pending cars ignore new requests; requests outside oneframe are dropped.
REQ-020 WAIT_MOVE SHALL select lowest-index pending car and go to ERASE_CAR; else stay.
REQ-021 ERASE_CAR SHALL plot the selected car footprint in BG_COLOUR (CAR_W*CAR_H cycles), then UPDATE_POS (1 cycle, plot low), then REDRAW_CAR (CAR_W*CAR_H cycles, CAR_COLOUR), then clear that car's pending bit and return to WAIT_MOVE.
REQ-022 Left: x-=STEP, clamped at 0; right: x+=STEP, clamped at SCREEN_W-CAR_W; straight: y-=STEP, wrapping to SCREEN_H-CAR_H when y<STEP.
REQ-023 A clamped move SHALL still erase and redraw (position unchanged).
REQ-024 Initial car i position SHALL be x=(i+1)*SCREEN_W/(NUM_CARS+1)-CAR_W/2, y=SCREEN_H-CAR_H, loaded on start.
REQ-025 plot SHALL be high exactly in DRAW_BG, DRAW_CAR, ERASE_CAR, REDRAW_CAR; x,y,colour valid whenever plot high.
REQ-026 start outside IDLE SHALL be ignored.

Reset
REQ-027 resetn low SHALL immediately force IDLE, plot=0, busy=0, x=0, y=0, colour=0, all pending bits and counters 0, including mid-draw.

Configuration
REQ-028 With RACE_COLLISION_EN defined, UPDATE_POS SHALL reject a move whose new footprint overlaps another car (position kept, redraw still occurs) and SHALL add output collision (1 bit) pulsing high one cycle per rejection.
REQ-029 Without RACE_COLLISION_EN, cars SHALL overlap freely and no collision port exists.

Structure
REQ-030 Shared package race_pkg SHALL hold the state enum, direction one-hot encodings and colour constants.
REQ-031 Sub-module race_pixel_scan SHALL provide the parametrised x/y raster counter with done flag, reused for background and sprite scans.

Verification
REQ-032 Reset then start pulse -> 19200 plot cycles BG_COLOUR, then 32 cycles CAR_COLOUR at car0 (51,116) and car1 (104,116), busy low after.
REQ-033 Car0 left at x=0 -> 16 erase, 1 update, 16 redraw cycles, x stays 0.
REQ-034 Both cars straight on same oneframe -> car0 serviced fully before car1; each y decrements by 1.
REQ-035 Car1 at y=0, straight -> redrawn at y=116.
REQ-036 resetn low during DRAW_BG pixel 5000 -> plot low same cycle, state IDLE, next start redraws from (0,0).
REQ-037 RACE_COLLISION_EN, car0 at (96,116), car1 at (100,116), car0 right -> collision pulses once, car0 stays x=96.
